// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encoding,
// opcode and ALU constants, mux-select codes, the control word layout and
// the next-state function.
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        WB_ALU   = 4'd5,
        MEM_LD   = 4'd6,
        WB_LD    = 4'd7,
        MEM_ST   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11,
        EXEC_LUI = 4'd12,
        WB_LUI   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_LUI  = 6'b110010;
    localparam logic [5:0] OP_BEQ  = 6'b110011;
    localparam logic [5:0] OP_JMP  = 6'b110101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       branch_type;
        logic       lui;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       halted;
    } ctrl_t;

    // Opcode classes: 00xxxx R-type, 01xxxx/10xxxx I-type (sign/zero
    // extended immediate), 11xxxx memory/flow instructions.
    function automatic state_t next_state(input state_t cur, input logic [5:0] op);
        state_t nxt;
        case (cur)
            IDLE:     nxt = FETCH;
            FETCH:    nxt = DECODE;
            DECODE: begin
                casez (op)
                    6'b00????:            nxt = EXEC_R;
                    6'b01????, 6'b10????: nxt = EXEC_I;
                    OP_LW:                nxt = MEM_LD;
                    OP_SW:                nxt = MEM_ST;
                    OP_LUI:               nxt = EXEC_LUI;
                    OP_BEQ:               nxt = BRANCH;
                    OP_JMP:               nxt = JUMP;
                    OP_HALT:              nxt = HALT;
                    default:              nxt = FETCH;
                endcase
            end
            EXEC_R:   nxt = WB_ALU;
            EXEC_I:   nxt = WB_ALU;
            MEM_LD:   nxt = WB_LD;
            EXEC_LUI: nxt = WB_LUI;
            WB_ALU:   nxt = FETCH;
            WB_LD:    nxt = FETCH;
            WB_LUI:   nxt = FETCH;
            MEM_ST:   nxt = FETCH;
            BRANCH:   nxt = FETCH;
            JUMP:     nxt = FETCH;
            HALT:     nxt = HALT;
            default:  nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-control-word decoder. Opcode is only consulted for
// the ALU operation and the immediate extension select in the execute states.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     st,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    // Every field defaults low; each state raises only the controls it owns.
    always_comb begin
        ctrl = '0;
        case (st)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = opcode[3:0];
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = opcode[3:0];
                ctrl.alu_src_b = (opcode[5:4] == 2'b01) ? SRCB_SEXT : SRCB_ZEXT;
            end
            WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            WB_LD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_ST: begin
                ctrl.mem_write = 1'b1;
            end
            EXEC_LUI: begin
                ctrl.alu_src_b = SRCB_ZEXT;
                ctrl.alu_op    = ALU_PASSB;
            end
            WB_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.lui        = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            BRANCH: begin
                // PC load is qualified by the datapath's compare result.
                ctrl.branch_type = 1'b1;
                ctrl.pc_source   = PCSRC_BRANCH;
                ctrl.pc_write    = 1'b0;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  IDLE     | post-reset, all controls low
//  FETCH    | read instruction, load IR, PC <= PC + 1
//  DECODE   | dispatch on opcode
//  EXEC_R   | ALU regA op regB
//  EXEC_I   | ALU regA op imm (sign or zero extended)
//  WB_ALU   | write ALU result to register file
//  MEM_LD   | memory read, MDR captures
//  WB_LD    | write MDR to register file
//  MEM_ST   | single-cycle memory write
//  BRANCH   | conditional PC load from branch target
//  JUMP     | unconditional PC load from jump target
//  HALT     | parked until reset
//  EXEC_LUI | ALU passes zero-extended immediate
//  WB_LUI   | write upper-immediate result
//
// The control word is decoded from the next state and registered alongside
// it, so every output is a flop that follows the state register exactly
// (Moore behaviour, no decode glitches) and is cleared by the async reset.
module control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        BranchType,
    output logic        LUI,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic [3:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);

    state_t      state_q;
    state_t      state_d;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_d;
    logic [15:0] count_q;

    assign state_d = next_state(state_q, opcode);

    ctrl_decode u_ctrl_decode (
        .st     (state_d),
        .opcode (opcode),
        .ctrl   (ctrl_d)
    );

    // State, registered control word and fetched-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_q == FETCH) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign PCWrite     = ctrl_q.pc_write;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign RegWrite    = ctrl_q.reg_write;
    assign BranchType  = ctrl_q.branch_type;
    assign LUI         = ctrl_q.lui;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign halted      = ctrl_q.halted;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: directed scenarios plus randomized instruction
// streams checked against a cycle-level behavioural model of the controller.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic        ALUSrcA, RegWrite, BranchType, LUI, halted;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp, state;
    logic [15:0] instr_count;
    logic [18:0] obs;

    int checks = 0;
    int errors = 0;

    control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .BranchType  (BranchType),
        .LUI         (LUI),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                  RegWrite, BranchType, LUI, PCSource, ALUSrcB, ALUOp, halted};

    // Cycles from FETCH until the next FETCH.
    function automatic int m_len(input logic [5:0] op);
        if (op[5:4] != 2'b11) return 4;
        case (op)
            6'b110000, 6'b110010:            return 4;
            6'b110001, 6'b110011, 6'b110101: return 3;
            default:                         return 2;
        endcase
    endfunction

    // State number occupied k cycles after FETCH.
    function automatic logic [3:0] m_state(input logic [5:0] op, input int k);
        if (k == 0) return 4'd1;
        if (k == 1) return 4'd2;
        if (op[5:4] == 2'b00) return (k == 2) ? 4'd3 : 4'd5;
        if (op[5:4] != 2'b11) return (k == 2) ? 4'd4 : 4'd5;
        case (op)
            6'b110000: return (k == 2) ? 4'd6 : 4'd7;
            6'b110010: return (k == 2) ? 4'd12 : 4'd13;
            6'b110001: return 4'd8;
            6'b110011: return 4'd9;
            6'b110101: return 4'd10;
            6'b111111: return 4'd11;
            default:   return 4'd1;
        endcase
    endfunction

    // Expected output vector for a state, in the same field order as obs.
    function automatic logic [18:0] m_ctrl(input logic [3:0] st, input logic [5:0] op);
        logic pcw, iord, memr, memw, irw, m2r, srca, regw, brt, lui_o, hlt;
        logic [1:0] pcs, srcb;
        logic [3:0] aop;
        {pcw, iord, memr, memw, irw, m2r, srca, regw, brt, lui_o, hlt} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 4'b0000;
        case (st)
            4'd1:  begin memr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            4'd3:  begin srca = 1; aop = op[3:0]; end
            4'd4:  begin srca = 1; aop = op[3:0]; srcb = (op[5:4] == 2'b01) ? 2'b10 : 2'b11; end
            4'd5:  regw = 1;
            4'd7:  begin regw = 1; m2r = 1; end
            4'd8:  memw = 1;
            4'd9:  begin brt = 1; pcs = 2'b01; end
            4'd10: begin pcw = 1; pcs = 2'b10; end
            4'd11: hlt = 1;
            4'd12: begin srcb = 2'b11; aop = 4'b1111; end
            4'd13: begin regw = 1; lui_o = 1; end
            default: ;
        endcase
        return {pcw, iord, memr, memw, irw, m2r, srca, regw, brt, lui_o, pcs, srcb, aop, hlt};
    endfunction

    function automatic logic [5:0] rand_op();
        int cls;
        logic [3:0] lo;
        cls = $urandom_range(0, 8);
        lo = 4'($urandom_range(0, 15));
        case (cls)
            0: return {2'b00, lo};
            1: return {2'b01, lo};
            2: return {2'b10, lo};
            3: return 6'b110000;
            4: return 6'b110001;
            5: return 6'b110010;
            6: return 6'b110011;
            7: return 6'b110101;
            default: begin
                while (lo inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd15})
                    lo = 4'($urandom_range(0, 15));
                return {2'b11, lo};
            end
        endcase
    endfunction

    // Reset pulse, then land on the negedge of the first FETCH cycle.
    task automatic start_run();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 6'b000000;
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        checks++;
        if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL first_fetch: state %0d PCWrite %b expected 1/1", state, PCWrite);
        end
    endtask

    task automatic test_r_type();
        logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd1};
        start_run();
        opcode = 6'b000010;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (state !== exp_st[k]) begin errors++; $display("FAIL r_state[%0d]: got %0d expected %0d", k, state, exp_st[k]); end
            checks++;
            if (RegWrite !== (k == 3)) begin errors++; $display("FAIL r_regwrite[%0d]: got %b expected %b", k, RegWrite, (k == 3)); end
            if (k == 2) begin
                checks++;
                if (ALUOp !== 4'b0010) begin errors++; $display("FAIL r_aluop: got %b expected 0010", ALUOp); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_i_type();
        logic [5:0] ops [2] = '{6'b010001, 6'b100001};
        logic [1:0] srcb [2] = '{2'b10, 2'b11};
        start_run();
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            for (int k = 0; k < 4; k++) begin
                if (k == 2) begin
                    checks++;
                    if (state !== 4'd4 || ALUSrcB !== srcb[i] || ALUSrcA !== 1'b1 || ALUOp !== 4'b0001) begin
                        errors++;
                        $display("FAIL i_exec[%0d]: state %0d srcb %b srca %b aluop %b expected 4/%b/1/0001",
                                 i, state, ALUSrcB, ALUSrcA, ALUOp, srcb[i]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_ld_st();
        int memw_n = 0;
        int ldwb_n = 0;
        int memw_at = -1;
        start_run();
        opcode = 6'b110000;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) opcode = 6'b110001;
            if (MemWrite === 1'b1) begin memw_n++; memw_at = c; end
            if (MemtoReg === 1'b1 && RegWrite === 1'b1) begin
                ldwb_n++;
                checks++;
                if (state !== 4'd7) begin errors++; $display("FAIL ld_wb_state: got %0d expected 7", state); end
            end
            @(negedge clk);
        end
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL ldst_total: state %0d after 7 cycles expected 1", state); end
        checks++;
        if (memw_n != 1 || memw_at != 6) begin errors++; $display("FAIL st_memwrite: %0d cycles at %0d expected 1 at 6", memw_n, memw_at); end
        checks++;
        if (ldwb_n != 1) begin errors++; $display("FAIL ld_wb_count: got %0d expected 1", ldwb_n); end
    endtask

    task automatic test_branch_jump_nop();
        start_run();
        opcode = 6'b110011;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'd9 || BranchType !== 1'b1 || PCWrite !== 1'b0 || PCSource !== 2'b01) begin
            errors++; $display("FAIL beq: state %0d bt %b pcw %b pcs %b expected 9/1/0/01", state, BranchType, PCWrite, PCSource);
        end
        @(negedge clk);
        opcode = 6'b110101;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'd10 || PCWrite !== 1'b1 || PCSource !== 2'b10) begin
            errors++; $display("FAIL jmp: state %0d pcw %b pcs %b expected 10/1/10", state, PCWrite, PCSource);
        end
        @(negedge clk);
        opcode = 6'b111000;
        @(negedge clk);
        checks++;
        if (state !== 4'd2) begin errors++; $display("FAIL nop_decode: got %0d expected 2", state); end
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || obs !== m_ctrl(4'd1, opcode)) begin
            errors++; $display("FAIL nop_refetch: state %0d outputs %h expected 1", state, obs);
        end
    endtask

    task automatic test_random();
        logic [15:0] cnt = 16'd0;
        logic [5:0] op;
        logic [3:0] es;
        int len;
        start_run();
        for (int n = 0; n < 300; n++) begin
            op = rand_op();
            opcode = op;
            len = m_len(op);
            for (int k = 0; k < len; k++) begin
                es = m_state(op, k);
                checks++;
                if (state !== es) begin errors++; $display("FAIL rnd_state op=%b k=%0d: got %0d expected %0d", op, k, state, es); end
                checks++;
                if (obs !== m_ctrl(es, op)) begin errors++; $display("FAIL rnd_ctrl op=%b k=%0d: got %h expected %h", op, k, obs, m_ctrl(es, op)); end
                checks++;
                if (instr_count !== ((k == 0) ? cnt : cnt + 16'd1)) begin
                    errors++; $display("FAIL rnd_count op=%b k=%0d: got %0d expected %0d", op, k, instr_count, (k == 0) ? cnt : cnt + 16'd1);
                end
                @(negedge clk);
            end
            cnt = cnt + 16'd1;
        end
    endtask

    task automatic test_reset_mid_store();
        start_run();
        opcode = 6'b110001;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'd8 || MemWrite !== 1'b1) begin errors++; $display("FAIL st_pre: state %0d MemWrite %b expected 8/1", state, MemWrite); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || state !== 4'd0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL st_async_reset: MemWrite %b state %0d count %0d expected 0/0/0", MemWrite, state, instr_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || PCWrite !== 1'b1) begin errors++; $display("FAIL st_refetch: state %0d PCWrite %b expected 1/1", state, PCWrite); end
    endtask

    task automatic test_halt_wrap();
        start_run();
        opcode = 6'b111000;
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1 release dut.count_q;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || instr_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_pre: state %0d count %h expected 1/ffff", state, instr_count);
        end
        opcode = 6'b111111;
        @(negedge clk);
        checks++;
        if (instr_count !== 16'h0000) begin errors++; $display("FAIL wrap: got %h expected 0000", instr_count); end
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            opcode = 6'($urandom_range(0, 63));
            checks++;
            if (state !== 4'd11 || obs !== m_ctrl(4'd11, opcode) || instr_count !== 16'h0000) begin
                errors++; $display("FAIL halt_hold[%0d]: state %0d outputs %h count %h expected 11/%h/0", c, state, obs, instr_count, m_ctrl(4'd11, opcode));
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL halt_reset: halted %b state %0d expected 0/0", halted, state); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_ld_st();
        test_branch_jump_nop();
        test_random();
        test_reset_mid_store();
        test_halt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
